// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle control unit.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH,
    S_JAL,
    S_LUI
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_J = 3'd3;
  localparam logic [2:0] IMM_U = 3'd4;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // Coarse ALU request from the FSM; FUNCT defers to funct3/funct7.
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // Immediate format implied by the opcode; unknown opcodes fall back to I.
  function automatic logic [2:0] imm_sel(input logic [6:0] opcode);
    case (opcode)
      OP_STORE:  return IMM_S;
      OP_BRANCH: return IMM_B;
      OP_JAL:    return IMM_J;
      OP_LUI:    return IMM_U;
      default:   return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/mc_ctrl_if.sv
// Memory port handshake between the control unit and the memory.
interface mc_ctrl_if;
  logic mem_req;
  logic mem_write;
  logic adr_src;
  logic mem_ready;

  modport master (output mem_req, output mem_write, output adr_src, input mem_ready);
  modport slave  (input mem_req, input mem_write, input adr_src, output mem_ready);
endinterface

// File: rtl/mc_ctrl_alu_dec.sv
// ALU operation decoder: maps the FSM's coarse request plus funct fields to alu_control.
module mc_ctrl_alu_dec
  import mc_ctrl_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       is_rtype,
  input  logic [1:0] alu_op,
  output logic [2:0] alu_control
);

  // Select the ALU function; I-type never subtracts since bit 30 is immediate data there.
  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  alu_control = (is_rtype && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multicycle RISC-V control unit.
//   state    | meaning
//   IDLE     | inactive, all outputs low
//   FETCH    | read instruction at PC, PC += 4 on completion
//   DECODE   | compute branch target, pick next state by opcode
//   MEMADR   | rs1 + imm address for lw/sw
//   MEMREAD  | load access pending
//   MEMWB    | write load data to rd
//   MEMWRITE | store access pending
//   EXECR    | R-type ALU operation
//   EXECI    | I-type ALU operation
//   ALUWB    | write ALUOut to rd
//   BRANCH   | compare rs1/rs2, conditionally load target into PC
//   JAL      | PC <- target, ALU forms old PC + 4
//   LUI      | 0 + U-immediate
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  mc_ctrl_if.master         mem,
  input  logic [31:0]       instr,
  input  logic              zero,
  output logic              ir_write,
  output logic              pc_write,
  output logic              reg_write,
  output logic [1:0]        result_src,
  output logic [1:0]        alu_src_a,
  output logic [1:0]        alu_src_b,
  output logic [2:0]        alu_control,
  output logic [2:0]        imm_src,
  output logic              illegal_instr,
  output logic              bus_err,
  output logic              retire
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t             state, next_state;
  logic [CNT_W-1:0]   wait_cnt;
  logic               waiting, tmo_fire;
  logic               mem_req_c, mem_write_c, adr_src_c;
  logic [1:0]         alu_op;
  logic               is_rtype;
  logic [6:0]         opcode;
  logic [2:0]         funct3;
  logic               unused_instr_bits;

  assign opcode            = instr[6:0];
  assign funct3            = instr[14:12];
  assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

  assign waiting  = (state == S_FETCH) || (state == S_MEMREAD) || (state == S_MEMWRITE);
  assign tmo_fire = waiting && !mem.mem_ready && (wait_cnt == CNT_W'(TIMEOUT_CYCLES));

  assign mem.mem_req   = mem_req_c;
  assign mem.mem_write = mem_write_c;
  assign mem.adr_src   = adr_src_c;

  mc_ctrl_alu_dec u_alu_dec (
    .funct3      (funct3),
    .funct7b5    (instr[30]),
    .is_rtype    (is_rtype),
    .alu_op      (alu_op),
    .alu_control (alu_control)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  // Wait counter: restarts on every state change, counts stalled cycles while waiting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        wait_cnt <= '0;
    else if (state != next_state)      wait_cnt <= '0;
    else if (waiting && !mem.mem_ready) wait_cnt <= wait_cnt + CNT_W'(1);
  end

  // Next-state and per-state datapath controls; a timeout overrides everything.
  always_comb begin
    next_state    = state;
    mem_req_c     = 1'b0;
    mem_write_c   = 1'b0;
    adr_src_c     = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    reg_write     = 1'b0;
    result_src    = RES_ALUOUT;
    alu_src_a     = SRCA_PC;
    alu_src_b     = SRCB_RS2;
    alu_op        = ALUOP_ADD;
    is_rtype      = 1'b0;
    imm_src       = IMM_I;
    illegal_instr = 1'b0;
    bus_err       = 1'b0;
    retire        = 1'b0;
    case (state)
      S_IDLE: next_state = S_FETCH;
      S_FETCH: begin
        mem_req_c = 1'b1;
        if (mem.mem_ready) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          alu_src_b  = SRCB_FOUR;
          result_src = RES_ALU;
          next_state = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        imm_src   = imm_sel(opcode);
        case (opcode)
          OP_LOAD, OP_STORE: next_state = S_MEMADR;
          OP_RTYPE:          next_state = S_EXECR;
          OP_ITYPE:          next_state = S_EXECI;
          OP_BRANCH:         next_state = S_BRANCH;
          OP_JAL:            next_state = S_JAL;
          OP_LUI:            next_state = S_LUI;
          default: begin
            illegal_instr = 1'b1;
            next_state    = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_IMM;
        imm_src    = (opcode == OP_STORE) ? IMM_S : IMM_I;
        next_state = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        mem_req_c = 1'b1;
        adr_src_c = 1'b1;
        if (mem.mem_ready) next_state = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = RES_MEM;
        reg_write  = 1'b1;
        retire     = 1'b1;
        next_state = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req_c   = 1'b1;
        mem_write_c = 1'b1;
        adr_src_c   = 1'b1;
        if (mem.mem_ready) begin
          retire     = 1'b1;
          next_state = S_FETCH;
        end
      end
      S_EXECR: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_RS2;
        alu_op     = ALUOP_FUNCT;
        is_rtype   = 1'b1;
        next_state = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_IMM;
        alu_op     = ALUOP_FUNCT;
        next_state = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write  = 1'b1;
        retire     = 1'b1;
        next_state = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_RS2;
        alu_op    = ALUOP_SUB;
        case (funct3)
          3'b000:  pc_write = zero;
          3'b001:  pc_write = !zero;
          default: pc_write = 1'b0;
        endcase
        retire     = 1'b1;
        next_state = S_FETCH;
      end
      S_JAL: begin
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        pc_write   = 1'b1;
        imm_src    = IMM_J;
        next_state = S_ALUWB;
      end
      S_LUI: begin
        alu_src_a  = SRCA_ZERO;
        alu_src_b  = SRCB_IMM;
        imm_src    = IMM_U;
        next_state = S_ALUWB;
      end
      default: next_state = S_IDLE;
    endcase
    if (tmo_fire) begin
      mem_req_c   = 1'b0;
      mem_write_c = 1'b0;
      adr_src_c   = 1'b0;
      bus_err     = 1'b1;
      next_state  = S_IDLE;
    end
  end

endmodule
